// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared widths, FSM state encoding and queue entry type for fetch.
// Rev    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue
// Brief  : Synchronous FIFO of {pc,instr} entries with flush; head is read
//          straight from the storage registers.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output fetch_entry_t     head_data
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // When full, a simultaneous push overwrites the slot being popped this edge.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= push_data;
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module : fetch_controller
// Brief  : PC sequencer + fetch queue with back-pressure, redirect, halt.
//          Optional out-of-range fault detection under FETCH_FAULT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2,
    parameter int          IMEM_WORDS  = 32
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                halt,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [ADDR_W-1:0]   if_pc,
    output logic                fault,
    output logic [1:0]          state
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  q_count;
    logic              q_valid;
    fetch_entry_t      q_head;
    fetch_entry_t      push_entry;
    logic              pop, pop_eff, push, flush;
    logic              space, try_capture, out_of_range;

    assign pop   = q_valid & if_ready;
    assign space = (q_count != CNT_W'(QUEUE_DEPTH)) | pop;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        push        = 1'b0;
        flush       = 1'b0;
        pop_eff     = pop;
        try_capture = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            pop_eff = 1'b0;
            pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
            state_d = halt ? S_HALT : S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (halt)        state_d = S_HALT;
                    else if (!space) state_d = S_HOLD;
                    else             try_capture = 1'b1;
                end
                S_HOLD: begin
                    if (halt) begin
                        state_d = S_HALT;
                    end else if (pop) begin
                        state_d     = S_FETCH;
                        try_capture = 1'b1;
                    end
                end
                S_HALT:  if (!halt) state_d = S_FETCH;
                default: state_d = state_q;
            endcase
            if (try_capture) begin
                if (out_of_range) begin
                    state_d = S_FAULT;
                end else begin
                    push = 1'b1;
                    pc_d = pc_q + PC_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= S_FETCH;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

`ifdef FETCH_FAULT_EN
    localparam logic [ADDR_W:0] FETCH_LIMIT = (ADDR_W+1)'(IMEM_WORDS) << 2;
    logic fault_q, fault_d;

    assign out_of_range = ({1'b0, pc_q} >= FETCH_LIMIT);

    always_comb begin
        fault_d = fault_q;
        if (redirect_valid)                   fault_d = 1'b0;
        else if (try_capture && out_of_range) fault_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end

    assign fault = fault_q;
`else
    logic unused_cfg;
    assign unused_cfg   = ^IMEM_WORDS;
    assign out_of_range = 1'b0;
    assign fault        = 1'b0;
`endif

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = imem_instr;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop_eff),
        .flush      (flush),
        .count      (q_count),
        .head_valid (q_valid),
        .head_data  (q_head)
    );

    assign imem_addr = pc_q;
    assign if_valid  = q_valid;
    assign if_instr  = q_head.instr;
    assign if_pc     = q_head.pc;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_controller
// Brief  : Directed self-checking bench for fetch_controller (default params).
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fault;
    logic [1:0]  state;

    int tests  = 0;
    int failed = 0;

    fetch_controller dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fault          (fault),
        .state          (state)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a recognisable word derived from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        if_ready       = 1'b1;
        #1;
        tick();
        tick();

        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);

        // Streaming with decode always ready
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stream_valid", {31'd0, if_valid}, 32'd1);
            check("stream_pc", if_pc, 32'(4 * k));
            check("stream_instr", if_instr, mem_word(32'(4 * k)));
        end

        // Back-pressure: queue fills, pc holds at 20
        if_ready = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("bp_valid", {31'd0, if_valid}, 32'd1);
        check("bp_state", {30'd0, state}, 32'd1);
        check("bp_addr", imem_addr, 32'd20);
        check("bp_head", if_pc, 32'd12);
        if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_drain_pc", if_pc, 32'(16 + 4 * k));
        end

        // Redirect while queue full
        if_ready = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        check("redir_valid", {31'd0, if_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h40);
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        tick();
        check("redir_pc0", if_pc, 32'h40);
        check("redir_instr0", if_instr, mem_word(32'h40));
        tick();
        check("redir_pc1", if_pc, 32'h44);

        // Halt with two queued entries
        if_ready = 1'b0;
        tick();
        halt = 1'b1;
        tick();
        check("halt_state", {30'd0, state}, 32'd2);
        check("halt_addr", imem_addr, 32'h4C);
        check("halt_head", if_pc, 32'h44);
        if_ready = 1'b1;
        tick();
        check("halt_drain", if_pc, 32'h48);
        tick();
        check("halt_empty", {31'd0, if_valid}, 32'd0);
        tick();
        check("halt_frozen", imem_addr, 32'h4C);
        check("halt_still", {30'd0, state}, 32'd2);
        halt = 1'b0;
        tick();
        check("resume_state", {30'd0, state}, 32'd0);
        tick();
        check("resume_pc", if_pc, 32'h4C);

        // Run up to the end of instruction memory
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("run_pc", if_pc, 32'(32'h4C + 4 * k));
        end
        tick();
`ifdef FETCH_FAULT_EN
        check("fault_flag", {31'd0, fault}, 32'd1);
        check("fault_state", {30'd0, state}, 32'd3);
        check("fault_valid", {31'd0, if_valid}, 32'd0);
        check("fault_addr", imem_addr, 32'h80);
        halt = 1'b1;
        tick();
        check("fault_halt_ign", {30'd0, state}, 32'd3);
        halt = 1'b0;
`else
        check("nofault_pc", if_pc, 32'h80);
        check("nofault_flag", {31'd0, fault}, 32'd0);
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        check("clr_fault", {31'd0, fault}, 32'd0);
        check("clr_state", {30'd0, state}, 32'd0);
        check("clr_addr", imem_addr, 32'h0);
        redirect_valid = 1'b0;
        tick();
        check("clr_pc", if_pc, 32'h0);

        // Asynchronous reset with two entries queued
        if_ready = 1'b0;
        tick();
        check("prerst_valid", {31'd0, if_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, if_valid}, 32'd0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_pc", if_pc, 32'h0);
        tick();
        rst      = 1'b0;
        if_ready = 1'b1;
        tick();
        check("post_rst_pc", if_pc, 32'h0);
        check("post_rst_valid", {31'd0, if_valid}, 32'd1);

`ifndef FETCH_FAULT_EN
        // pc wraps from the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        tick();
        check("wrap_head", if_pc, 32'hFFFF_FFFC);
        check("wrap_next", imem_addr, 32'h0);
        tick();
        check("wrap_pc0", if_pc, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
